// File: rtl/histo_pkg.sv
// histo_pkg: shared constants and types for the
// histogram stream receiver.
package histo_pkg;

    localparam int HISTO_BINS   = 1024;
    localparam int HISTO_DATA_W = 10;
    localparam int HISTO_CNT_W  = 11;
    localparam int HISTO_SUM_W  = 20;
    localparam int HISTO_ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_CHECK = 2'd2
    } histo_rx_state_t;

    // Word counter increment that sticks at all-ones.
    function automatic logic [HISTO_CNT_W-1:0] cnt_sat_inc(
        input logic [HISTO_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/histo_buf_dp.sv
// histo_buf_dp: simple dual-port RAM, one write port,
// one registered read port, no reset on contents.
module histo_buf_dp #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 10,
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Write port and registered read port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/histo_stream_rx.sv
// histo_stream_rx: synchronises the histogram stream,
// captures one burst and reports sum / peak results.
module histo_stream_rx
    import histo_pkg::*;
#(
    parameter int BINS        = HISTO_BINS,
    parameter int DATA_W      = HISTO_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       histo_data,
    input  logic                    histo_valid,
    input  logic                    histo_clock,
    input  logic [HISTO_ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    burst_done,
    output logic                    burst_err,
    output logic [HISTO_CNT_W-1:0]  word_count,
    output logic [HISTO_SUM_W-1:0]  bin_sum,
    output logic [HISTO_ADDR_W-1:0] peak_idx,
    output logic [DATA_W-1:0]       peak_val,
    output logic                    busy
);

    localparam logic [HISTO_CNT_W-1:0] L_BINS = HISTO_CNT_W'(BINS);

    logic [DATA_W-1:0] w_data_s;
    logic              w_valid_s;
    logic              w_clk_s;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_data_s  = histo_data;
            assign w_valid_s = histo_valid;
            assign w_clk_s   = histo_clock;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][DATA_W-1:0] r_data_q;
            logic [SYNC_STAGES-1:0]             r_valid_q;
            logic [SYNC_STAGES-1:0]             r_clk_q;

            // Equal-depth chains keep data, valid and strobe aligned
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_q  <= '0;
                    r_valid_q <= '0;
                    r_clk_q   <= '0;
                end else begin
                    r_data_q[0]  <= histo_data;
                    r_valid_q[0] <= histo_valid;
                    r_clk_q[0]   <= histo_clock;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        r_data_q[i]  <= r_data_q[i-1];
                        r_valid_q[i] <= r_valid_q[i-1];
                        r_clk_q[i]   <= r_clk_q[i-1];
                    end
                end
            end

            assign w_data_s  = r_data_q[SYNC_STAGES-1];
            assign w_valid_s = r_valid_q[SYNC_STAGES-1];
            assign w_clk_s   = r_clk_q[SYNC_STAGES-1];
        end
    endgenerate

    logic r_clk_d;
    logic r_valid_d;
    logic w_strobe;
    logic w_valid_rise;
    logic w_valid_fall;

    assign w_strobe     = w_clk_s ^ r_clk_d;
    assign w_valid_rise = w_valid_s & ~r_valid_d;
    assign w_valid_fall = ~w_valid_s & r_valid_d;

    histo_rx_state_t r_state;

    logic [HISTO_CNT_W-1:0]  r_wr_ptr;
    logic [HISTO_SUM_W-1:0]  r_sum;
    logic [HISTO_ADDR_W-1:0] r_pk_idx;
    logic [DATA_W-1:0]       r_pk_val;
    logic                    r_ovf;

    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic [HISTO_CNT_W-1:0]  r_word_count;
    logic [HISTO_SUM_W-1:0]  r_bin_sum;
    logic [HISTO_ADDR_W-1:0] r_peak_idx;
    logic [DATA_W-1:0]       r_peak_val;

    logic                    w_start;
    logic                    w_run;
    logic                    w_accept;
    logic                    w_in_range;
    logic                    w_we;
    logic                    w_new_peak;
    logic [HISTO_CNT_W-1:0]  w_ptr_base;
    logic [HISTO_SUM_W-1:0]  w_sum_base;
    logic [HISTO_ADDR_W-1:0] w_pk_idx_base;
    logic [DATA_W-1:0]       w_pk_val_base;
    logic                    w_ovf_base;
    logic [HISTO_CNT_W-1:0]  w_ptr_next;
    logic [HISTO_SUM_W-1:0]  w_sum_next;
    logic [HISTO_ADDR_W-1:0] w_pk_idx_next;
    logic [DATA_W-1:0]       w_pk_val_next;
    logic                    w_ovf_next;

    // Running burst state; a new burst starts from zero so that
    // a strobe coinciding with the valid rise becomes word 0
    always_comb begin
        w_start    = (r_state == ST_IDLE) && w_valid_rise;
        w_run      = w_start ||
                     ((r_state == ST_RECV) && !w_valid_fall);
        w_accept   = w_strobe && w_run;

        w_ptr_base    = w_start ? '0 : r_wr_ptr;
        w_sum_base    = w_start ? '0 : r_sum;
        w_pk_idx_base = w_start ? '0 : r_pk_idx;
        w_pk_val_base = w_start ? '0 : r_pk_val;
        w_ovf_base    = w_start ? 1'b0 : r_ovf;

        w_in_range = w_ptr_base < L_BINS;
        w_we       = w_accept && w_in_range && !rst;
        w_new_peak = w_we && (w_data_s > w_pk_val_base);

        w_ptr_next    = w_accept ? cnt_sat_inc(w_ptr_base)
                                 : w_ptr_base;
        w_sum_next    = w_we ? w_sum_base + HISTO_SUM_W'(w_data_s)
                             : w_sum_base;
        w_pk_idx_next = w_new_peak ? w_ptr_base[HISTO_ADDR_W-1:0]
                                   : w_pk_idx_base;
        w_pk_val_next = w_new_peak ? w_data_s : w_pk_val_base;
        w_ovf_next    = w_ovf_base | (w_accept & ~w_in_range);
    end

    // Burst FSM with registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_clk_d      <= 1'b0;
            r_valid_d    <= 1'b0;
            r_wr_ptr     <= '0;
            r_sum        <= '0;
            r_pk_idx     <= '0;
            r_pk_val     <= '0;
            r_ovf        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= '0;
            r_bin_sum    <= '0;
            r_peak_idx   <= '0;
            r_peak_val   <= '0;
        end else begin
            r_clk_d   <= w_clk_s;
            r_valid_d <= w_valid_s;
            r_done    <= 1'b0;
            r_err     <= 1'b0;

            if (w_run) begin
                r_wr_ptr <= w_ptr_next;
                r_sum    <= w_sum_next;
                r_pk_idx <= w_pk_idx_next;
                r_pk_val <= w_pk_val_next;
                r_ovf    <= w_ovf_next;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_RECV;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (w_valid_fall) begin
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_word_count <= r_wr_ptr;
                    if ((r_wr_ptr == L_BINS) && !r_ovf) begin
                        r_done     <= 1'b1;
                        r_bin_sum  <= r_sum;
                        r_peak_idx <= r_pk_idx;
                        r_peak_val <= r_pk_val;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    histo_buf_dp #(
        .DEPTH  (BINS),
        .DATA_W (DATA_W),
        .ADDR_W (HISTO_ADDR_W)
    ) u_buf (
        .i_clk   (clk),
        .i_we    (w_we),
        .i_waddr (w_ptr_base[HISTO_ADDR_W-1:0]),
        .i_wdata (w_data_s),
        .i_raddr (rd_addr),
        .o_rdata (rd_data)
    );

    assign burst_done = r_done;
    assign burst_err  = r_err;
    assign word_count = r_word_count;
    assign bin_sum    = r_bin_sum;
    assign peak_idx   = r_peak_idx;
    assign peak_val   = r_peak_val;
    assign busy       = r_busy;

endmodule

// File: tb/tb_histo_stream_rx.sv
// tb_histo_stream_rx: drives one stream into two receivers
// (SYNC_STAGES 0 and 2) and checks them against a burst model.
module tb_histo_stream_rx;

    localparam int BINS = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [9:0] histo_data;
    logic       histo_valid;
    logic       histo_clock;
    logic [9:0] rd_addr;

    logic [1:0][9:0]  rdd;
    logic [1:0]       dn;
    logic [1:0]       er;
    logic [1:0][10:0] wc;
    logic [1:0][19:0] bs;
    logic [1:0][9:0]  pi;
    logic [1:0][9:0]  pv;
    logic [1:0]       bz;

    histo_stream_rx #(.BINS(BINS), .DATA_W(10), .SYNC_STAGES(0)) u_dut0 (
        .clk(clk), .rst(rst), .histo_data(histo_data),
        .histo_valid(histo_valid), .histo_clock(histo_clock),
        .rd_addr(rd_addr), .rd_data(rdd[0]), .burst_done(dn[0]),
        .burst_err(er[0]), .word_count(wc[0]), .bin_sum(bs[0]),
        .peak_idx(pi[0]), .peak_val(pv[0]), .busy(bz[0])
    );

    histo_stream_rx #(.BINS(BINS), .DATA_W(10), .SYNC_STAGES(2)) u_dut2 (
        .clk(clk), .rst(rst), .histo_data(histo_data),
        .histo_valid(histo_valid), .histo_clock(histo_clock),
        .rd_addr(rd_addr), .rd_data(rdd[1]), .burst_done(dn[1]),
        .burst_err(er[1]), .word_count(wc[1]), .bin_sum(bs[1]),
        .peak_idx(pi[1]), .peak_val(pv[1]), .busy(bz[1])
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int sync_of[2] = '{0, 2};

    int done_n[2] = '{0, 0};
    int err_n[2]  = '{0, 0};
    int done_cyc[2];
    int err_cyc[2];
    int d0[2];
    int r0[2];
    int fall;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (dn[k]) begin done_n[k]++; done_cyc[k] = cyc; end
            if (er[k]) begin err_n[k]++;  err_cyc[k]  = cyc; end
        end
    end

    // Reference model: buffer image plus last-good-burst results
    logic [9:0]      m_mem [BINS];
    bit [BINS-1:0]   m_known = '0;
    logic [9:0]      words[$];
    logic [10:0]     e_wc = '0;
    logic [19:0]     e_sum = '0;
    logic [9:0]      e_pidx = '0;
    logic [9:0]      e_pval = '0;

    function automatic void expect_results();
        int n;
        int mx;
        int s;
        n = words.size();
        e_wc = (n > 2047) ? 11'd2047 : 11'(n);
        if (n == BINS) begin
            mx = 0;
            s = 0;
            foreach (words[i]) begin
                s += int'(words[i]);
                if (int'(words[i]) > mx) mx = int'(words[i]);
            end
            e_sum = 20'(s);
            e_pval = 10'(mx);
            for (int i = BINS - 1; i >= 0; i--)
                if (int'(words[i]) == mx) e_pidx = 10'(i);
        end
    endfunction

    task automatic snap();
        for (int k = 0; k < 2; k++) begin
            d0[k] = done_n[k];
            r0[k] = err_n[k];
        end
    endtask

    // Stream driver; entered and left #1 after a rising clk edge
    task automatic send_burst(input int period, input int idle,
                              input bit drop);
        for (int i = 0; i < idle; i++) begin
            histo_data = 10'($urandom);
            histo_clock = ~histo_clock;
            repeat (period) @(posedge clk);
            #1;
        end
        histo_valid = 1'b1;
        foreach (words[i]) begin
            histo_data = words[i];
            histo_clock = ~histo_clock;
            if (i < BINS) begin
                m_mem[i] = words[i];
                m_known[i] = 1'b1;
            end
            repeat (period) @(posedge clk);
            #1;
        end
        if (drop) histo_valid = 1'b0;
        fall = cyc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        histo_data = '0;
        histo_valid = 1'b0;
        histo_clock = 1'b0;
        rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({dn[k], er[k], bz[k], wc[k], bs[k], pi[k], pv[k]} !== '0) begin
                miscompares++;
                $display("FAIL reset_state dut%0d got d=%b e=%b b=%b wc=%0d sum=%0d pi=%0d pv=%0d want all 0",
                         k, dn[k], er[k], bz[k], wc[k], bs[k], pi[k], pv[k]);
            end
        end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if ({dn[k], er[k], bz[k], wc[k]} !== '0) begin
                miscompares++;
                $display("FAIL post_reset dut%0d got d=%b e=%b b=%b wc=%0d want 0",
                         k, dn[k], er[k], bz[k], wc[k]);
            end
        end
    endtask

    task automatic test_good_ramp();
        int a;
        words.delete();
        for (int i = 0; i < BINS; i++) words.push_back(10'(i));
        snap();
        send_burst(1, 0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        expect_results();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (done_n[k] - d0[k] != 1 || err_n[k] - r0[k] != 0) begin
                miscompares++;
                $display("FAIL ramp_pulse dut%0d got done=%0d err=%0d want 1/0",
                         k, done_n[k] - d0[k], err_n[k] - r0[k]);
            end
            vectors++;
            if (done_cyc[k] - fall != sync_of[k] + 2) begin
                miscompares++;
                $display("FAIL ramp_latency dut%0d got %0d want %0d",
                         k, done_cyc[k] - fall, sync_of[k] + 2);
            end
            vectors++;
            if ({wc[k], bs[k], pi[k], pv[k]} !== {e_wc, e_sum, e_pidx, e_pval}) begin
                miscompares++;
                $display("FAIL ramp_result dut%0d got wc=%0d sum=%0d pi=%0d pv=%0d want %0d %0d %0d %0d",
                         k, wc[k], bs[k], pi[k], pv[k], e_wc, e_sum, e_pidx, e_pval);
            end
        end
        for (int j = 0; j < 6; j++) begin
            a = (j == 0) ? 5 : int'($urandom_range(0, BINS - 1));
            rd_addr = 10'(a);
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (rdd[k] !== m_mem[a]) begin
                    miscompares++;
                    $display("FAIL ramp_read dut%0d addr=%0d got %0d want %0d",
                             k, a, rdd[k], m_mem[a]);
                end
            end
        end
    endtask

    task automatic test_short();
        words.delete();
        for (int i = 0; i < 1000; i++) words.push_back(10'($urandom));
        snap();
        send_burst(1, 0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        expect_results();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (done_n[k] - d0[k] != 0 || err_n[k] - r0[k] != 1) begin
                miscompares++;
                $display("FAIL short_pulse dut%0d got done=%0d err=%0d want 0/1",
                         k, done_n[k] - d0[k], err_n[k] - r0[k]);
            end
            vectors++;
            if (err_cyc[k] - fall != sync_of[k] + 2) begin
                miscompares++;
                $display("FAIL short_latency dut%0d got %0d want %0d",
                         k, err_cyc[k] - fall, sync_of[k] + 2);
            end
            vectors++;
            if ({wc[k], bs[k], pi[k], pv[k]} !== {e_wc, e_sum, e_pidx, e_pval}) begin
                miscompares++;
                $display("FAIL short_result dut%0d got wc=%0d sum=%0d pi=%0d pv=%0d want %0d %0d %0d %0d",
                         k, wc[k], bs[k], pi[k], pv[k], e_wc, e_sum, e_pidx, e_pval);
            end
        end
    endtask

    task automatic test_overflow();
        int a;
        words.delete();
        for (int i = 0; i < BINS; i++) words.push_back(10'd7);
        for (int i = 0; i < 6; i++) words.push_back(10'd9);
        snap();
        send_burst(1, 0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        expect_results();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (done_n[k] - d0[k] != 0 || err_n[k] - r0[k] != 1) begin
                miscompares++;
                $display("FAIL ovf_pulse dut%0d got done=%0d err=%0d want 0/1",
                         k, done_n[k] - d0[k], err_n[k] - r0[k]);
            end
            vectors++;
            if ({wc[k], bs[k], pi[k], pv[k]} !== {e_wc, e_sum, e_pidx, e_pval}) begin
                miscompares++;
                $display("FAIL ovf_result dut%0d got wc=%0d sum=%0d pi=%0d pv=%0d want %0d %0d %0d %0d",
                         k, wc[k], bs[k], pi[k], pv[k], e_wc, e_sum, e_pidx, e_pval);
            end
        end
        for (int j = 0; j < 7; j++) begin
            a = (j == 6) ? BINS - 1 : j;
            rd_addr = 10'(a);
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (rdd[k] !== m_mem[a]) begin
                    miscompares++;
                    $display("FAIL ovf_read dut%0d addr=%0d got %0d want %0d",
                             k, a, rdd[k], m_mem[a]);
                end
            end
        end
    endtask

    task automatic test_peak_tie();
        words.delete();
        for (int i = 0; i < BINS; i++)
            words.push_back((i == 10 || i == 500) ? 10'd900 : 10'd1);
        snap();
        send_burst(1, 0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        expect_results();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (done_n[k] - d0[k] != 1 || err_n[k] - r0[k] != 0) begin
                miscompares++;
                $display("FAIL tie_pulse dut%0d got done=%0d err=%0d want 1/0",
                         k, done_n[k] - d0[k], err_n[k] - r0[k]);
            end
            vectors++;
            if ({wc[k], bs[k], pi[k], pv[k]} !== {e_wc, e_sum, e_pidx, e_pval}) begin
                miscompares++;
                $display("FAIL tie_result dut%0d got wc=%0d sum=%0d pi=%0d pv=%0d want %0d %0d %0d %0d",
                         k, wc[k], bs[k], pi[k], pv[k], e_wc, e_sum, e_pidx, e_pval);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int a;
        words.delete();
        for (int i = 0; i < 300; i++) words.push_back(10'($urandom));
        snap();
        send_burst(1, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (bz[k] !== 1'b1) begin
                miscompares++;
                $display("FAIL mid_busy dut%0d got %b want 1", k, bz[k]);
            end
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        histo_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        e_wc = '0;
        e_sum = '0;
        e_pidx = '0;
        e_pval = '0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (done_n[k] != d0[k] || err_n[k] != r0[k]) begin
                miscompares++;
                $display("FAIL abort_pulse dut%0d got done=%0d err=%0d want 0/0",
                         k, done_n[k] - d0[k], err_n[k] - r0[k]);
            end
            vectors++;
            if ({bz[k], wc[k], bs[k], pi[k], pv[k]} !== '0) begin
                miscompares++;
                $display("FAIL abort_zero dut%0d got b=%b wc=%0d sum=%0d pi=%0d pv=%0d want 0",
                         k, bz[k], wc[k], bs[k], pi[k], pv[k]);
            end
        end
        words.delete();
        for (int i = 0; i < BINS; i++) words.push_back(10'($urandom));
        snap();
        send_burst(1, 0, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        expect_results();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (done_n[k] - d0[k] != 1 || err_n[k] - r0[k] != 0) begin
                miscompares++;
                $display("FAIL regood_pulse dut%0d got done=%0d err=%0d want 1/0",
                         k, done_n[k] - d0[k], err_n[k] - r0[k]);
            end
            vectors++;
            if ({wc[k], bs[k], pi[k], pv[k]} !== {e_wc, e_sum, e_pidx, e_pval}) begin
                miscompares++;
                $display("FAIL regood_result dut%0d got wc=%0d sum=%0d pi=%0d pv=%0d want %0d %0d %0d %0d",
                         k, wc[k], bs[k], pi[k], pv[k], e_wc, e_sum, e_pidx, e_pval);
            end
        end
        for (int j = 0; j < 5; j++) begin
            a = int'($urandom_range(0, BINS - 1));
            rd_addr = 10'(a);
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (rdd[k] !== m_mem[a]) begin
                    miscompares++;
                    $display("FAIL regood_read dut%0d addr=%0d got %0d want %0d",
                             k, a, rdd[k], m_mem[a]);
                end
            end
        end
    endtask

    task automatic test_slow_idle_strobes();
        words.delete();
        for (int i = 0; i < BINS; i++) words.push_back(10'($urandom));
        snap();
        send_burst(3, 5, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        expect_results();
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (done_n[k] - d0[k] != 1 || err_n[k] - r0[k] != 0) begin
                miscompares++;
                $display("FAIL slow_pulse dut%0d got done=%0d err=%0d want 1/0",
                         k, done_n[k] - d0[k], err_n[k] - r0[k]);
            end
            vectors++;
            if (done_cyc[k] - fall != sync_of[k] + 2) begin
                miscompares++;
                $display("FAIL slow_latency dut%0d got %0d want %0d",
                         k, done_cyc[k] - fall, sync_of[k] + 2);
            end
            vectors++;
            if ({wc[k], bs[k], pi[k], pv[k]} !== {e_wc, e_sum, e_pidx, e_pval}) begin
                miscompares++;
                $display("FAIL slow_result dut%0d got wc=%0d sum=%0d pi=%0d pv=%0d want %0d %0d %0d %0d",
                         k, wc[k], bs[k], pi[k], pv[k], e_wc, e_sum, e_pidx, e_pval);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_ramp();
        test_short();
        test_overflow();
        test_peak_tie();
        test_reset_mid_burst();
        test_slow_idle_strobes();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
